// File: rtl/module_teclado_bcd_if.sv
// Keypad/BCD bundle: row sense and column drive towards the keypad, decoded result towards
// the display driver and any consumer of key events.
interface module_teclado_bcd_if;
    logic [3:0] fila_i;
    logic [3:0] columna_o;
    logic [7:0] bcd_o;
    logic [3:0] tecla_o;
    logic       tecla_vld_o;
    logic       enter_o;

    // Scanner side
    modport master (
        input  fila_i,
        output columna_o,
        output bcd_o,
        output tecla_o,
        output tecla_vld_o,
        output enter_o
    );

    // Keypad / consumer side
    modport slave (
        output fila_i,
        input  columna_o,
        input  bcd_o,
        input  tecla_o,
        input  tecla_vld_o,
        input  enter_o
    );
endinterface

// File: rtl/module_teclado_bcd.sv
// 4x4 matrix keypad scanner: column-drive / row-sense (active-low), press and release
// debounce on a slow scan tick, key decode and two-digit packed BCD entry.
module module_teclado_bcd #(
    parameter int unsigned SCAN_TICKS     = 27000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    module_teclado_bcd_if.master        bus_io
);

    localparam int unsigned      TickW    = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [TickW-1:0] TickLoad = TickW'(SCAN_TICKS - 1);
    localparam int unsigned      CntW     = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CntW-1:0]  CntMax   = CntW'(DEBOUNCE_SCANS);
    localparam logic [CntW-1:0]  CntOne   = CntW'(1);

    typedef enum logic [1:0] {StScan, StDebounce, StHeld} state_e;

    logic [3:0]       fila_meta_q, fila_s_q;
    logic [TickW-1:0] tick_cnt_q;
    logic             tick;
    state_e           state_q;
    logic [3:0]       columna_q, pat_q, key_q;
    logic [CntW-1:0]  cnt_q, rel_cnt_q, cnt_inc, rel_inc;
    logic [7:0]       bcd_q;
    logic [3:0]       tecla_q;
    logic             vld_q, enter_q;
    logic             row_hit;
    logic [1:0]       row_idx, col_idx;
    logic [3:0]       kc, acc_code;
    logic             accept;

    // Two-flop synchronizer for the asynchronous row inputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fila_meta_q <= 4'b1111;
            fila_s_q    <= 4'b1111;
        end else begin
            fila_meta_q <= bus_io.fila_i;
            fila_s_q    <= fila_meta_q;
        end
    end

    // Scan timebase: reloading down-counter, tick on zero
    always_ff @(posedge clk_i) begin
        if (rst_i || tick) tick_cnt_q <= TickLoad;
        else               tick_cnt_q <= tick_cnt_q - 1'b1;
    end

    assign tick    = (tick_cnt_q == '0);
    assign cnt_inc = cnt_q + 1'b1;
    assign rel_inc = rel_cnt_q + 1'b1;

    // Row / column decode; more than one row low is treated as no hit
    always_comb begin
        row_hit = 1'b1;
        row_idx = 2'd0;
        case (fila_s_q)
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_hit = 1'b0;
        endcase
        col_idx = 2'd0;
        case (columna_q)
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
    end

    // Keymap: '*' -> E, '#' -> F
    always_comb begin
        kc = 4'h0;
        case ({row_idx, col_idx})
            4'h0: kc = 4'h1;  4'h1: kc = 4'h2;  4'h2: kc = 4'h3;  4'h3: kc = 4'hA;
            4'h4: kc = 4'h4;  4'h5: kc = 4'h5;  4'h6: kc = 4'h6;  4'h7: kc = 4'hB;
            4'h8: kc = 4'h7;  4'h9: kc = 4'h8;  4'hA: kc = 4'h9;  4'hB: kc = 4'hC;
            4'hC: kc = 4'hE;  4'hD: kc = 4'h0;  4'hE: kc = 4'hF;  default: kc = 4'hD;
        endcase
    end

    // Key acceptance on a tick; the single-scan case covers DEBOUNCE_SCANS == 1
    always_comb begin
        accept   = 1'b0;
        acc_code = key_q;
        if (tick) begin
            if (state_q == StScan && row_hit && CntMax == CntOne) begin
                accept   = 1'b1;
                acc_code = kc;
            end else if (state_q == StDebounce && fila_s_q == pat_q && cnt_inc == CntMax) begin
                accept = 1'b1;
            end
        end
    end

    // Scan/debounce FSM with registered key-event outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StScan;
            columna_q <= 4'b1110;
            pat_q     <= 4'b1111;
            key_q     <= 4'h0;
            cnt_q     <= '0;
            rel_cnt_q <= '0;
            bcd_q     <= 8'h00;
            tecla_q   <= 4'h0;
            vld_q     <= 1'b0;
            enter_q   <= 1'b0;
        end else begin
            vld_q   <= 1'b0;
            enter_q <= 1'b0;
            if (accept) begin
                tecla_q <= acc_code;
                vld_q   <= 1'b1;
                if (acc_code <= 4'h9)      bcd_q   <= {bcd_q[3:0], acc_code};
                else if (acc_code == 4'hE) bcd_q   <= 8'h00;
                else if (acc_code == 4'hF) enter_q <= 1'b1;
            end
            if (tick) begin
                unique case (state_q)
                    StScan: begin
                        if (row_hit) begin
                            pat_q     <= fila_s_q;
                            key_q     <= kc;
                            cnt_q     <= CntOne;
                            rel_cnt_q <= '0;
                            state_q   <= (CntMax == CntOne) ? StHeld : StDebounce;
                        end else begin
                            columna_q <= {columna_q[2:0], columna_q[3]};
                        end
                    end
                    StDebounce: begin
                        if (fila_s_q == pat_q) begin
                            cnt_q <= cnt_inc;
                            if (cnt_inc == CntMax) state_q <= StHeld;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= StScan;
                        end
                    end
                    StHeld: begin
                        // Only all-rows-high counts as released; any low row restarts the count
                        if (fila_s_q == 4'b1111) begin
                            if (rel_inc == CntMax) begin
                                rel_cnt_q <= '0;
                                state_q   <= StScan;
                            end else begin
                                rel_cnt_q <= rel_inc;
                            end
                        end else begin
                            rel_cnt_q <= '0;
                        end
                    end
                    default: state_q <= StScan;
                endcase
            end
        end
    end

    assign bus_io.columna_o   = columna_q;
    assign bus_io.bcd_o       = bcd_q;
    assign bus_io.tecla_o     = tecla_q;
    assign bus_io.tecla_vld_o = vld_q;
    assign bus_io.enter_o     = enter_q;

endmodule

// File: tb/tb_module_teclado_bcd.sv
// Directed bench for module_teclado_bcd with a keypad model driving rows from the columns.
module tb_module_teclado_bcd;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    module_teclado_bcd_if bus ();

    module_teclado_bcd #(
        .SCAN_TICKS     (4),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .bus_io (bus)
    );

    always #5 clk_i = ~clk_i;

    // Keypad model: pressed rows pull low only while their column is driven
    logic       key_dn   = 1'b0;
    logic [3:0] key_rows = 4'b0001;
    logic [1:0] key_col  = 2'd0;
    assign bus.fila_i = (key_dn && bus.columna_o[key_col] == 1'b0) ? ~key_rows : 4'hF;

    int n_vec = 0;
    int n_err = 0;

    // Event monitor on the falling edge
    int         vld_cnt = 0, enter_cnt = 0, wide_vld = 0, wide_enter = 0;
    logic [3:0] last_tecla = 4'h0;
    logic       vld_prev = 1'b0, enter_prev = 1'b0;
    always @(negedge clk_i) begin
        if (bus.tecla_vld_o === 1'b1) begin
            vld_cnt++;
            last_tecla = bus.tecla_o;
            if (vld_prev) wide_vld++;
        end
        if (bus.enter_o === 1'b1) begin
            enter_cnt++;
            if (enter_prev) wide_enter++;
        end
        vld_prev   = (bus.tecla_vld_o === 1'b1);
        enter_prev = (bus.enter_o === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic wait_pulse(input int n0, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (vld_cnt != n0) break;
            cycles(1);
        end
    endtask

    task automatic wait_col(input logic [3:0] want);
        int found = 0;
        for (int i = 0; i < 40; i++) begin
            cycles(1);
            if (bus.columna_o == want) begin
                found = 1;
                break;
            end
        end
        if (found == 0) check("col_wait", {28'h0, bus.columna_o}, {28'h0, want});
    endtask

    // Clean press, short hold, release, then check the event and the BCD register
    task automatic press_key(input string tag, input int r, input int c,
                             input logic [3:0] exp_code, input logic [7:0] exp_bcd);
        int n0 = vld_cnt;
        key_rows = 4'(1 << r);
        key_col  = 2'(c);
        key_dn   = 1'b1;
        wait_pulse(n0, 80);
        cycles(8);
        key_dn = 1'b0;
        cycles(24);
        check({tag, "_vld"}, vld_cnt - n0, 1);
        check({tag, "_tecla"}, {28'h0, last_tecla}, {28'h0, exp_code});
        check({tag, "_bcd"}, {24'h0, bus.bcd_o}, {24'h0, exp_bcd});
    endtask

    initial begin
        int n0, e0;
        logic [3:0] seen;
        logic [3:0] col_seq [5];
        col_seq[0] = 4'b1110; col_seq[1] = 4'b1101; col_seq[2] = 4'b1011;
        col_seq[3] = 4'b0111; col_seq[4] = 4'b1110;

        // 1. Reset values and idle column rotation
        rst_i = 1'b1;
        cycles(2);
        rst_i = 1'b0;
        check("rst_bcd", {24'h0, bus.bcd_o}, 32'h00);
        check("rst_tecla", {28'h0, bus.tecla_o}, 32'h0);
        check("rst_vld", {31'h0, bus.tecla_vld_o}, 32'h0);
        check("rst_enter", {31'h0, bus.enter_o}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("col_step%0d", i), {28'h0, bus.columna_o}, {28'h0, col_seq[i]});
            cycles(4);
        end

        // 2. Digit entry: 5, 7, 3
        press_key("k5", 1, 1, 4'h5, 8'h05);
        press_key("k7", 2, 0, 4'h7, 8'h57);
        press_key("k3", 0, 2, 4'h3, 8'h73);

        // 4. Function keys
        e0 = enter_cnt;
        press_key("khash", 3, 2, 4'hF, 8'h73);
        check("hash_enter", enter_cnt - e0, 1);
        press_key("kstar", 3, 0, 4'hE, 8'h00);
        press_key("kB", 1, 3, 4'hB, 8'h00);
        check("enter_only_hash", enter_cnt - e0, 1);

        // 3. Bouncing '9': one low tick, one high tick, then stable
        n0       = vld_cnt;
        key_rows = 4'b0100;
        key_col  = 2'd2;
        wait_col(4'b1011);
        key_dn = 1'b1;
        cycles(4);
        key_dn = 1'b0;
        cycles(4);
        key_dn = 1'b1;
        check("bounce_novld", vld_cnt - n0, 0);
        wait_pulse(n0, 80);
        cycles(8);
        key_dn = 1'b0;
        cycles(24);
        check("bounce_vld", vld_cnt - n0, 1);
        check("bounce_tecla", {28'h0, last_tecla}, 32'h9);
        check("bounce_bcd", {24'h0, bus.bcd_o}, 32'h09);

        // 5. Long hold of '1' with two separated one-tick release glitches
        n0       = vld_cnt;
        key_rows = 4'b0001;
        key_col  = 2'd0;
        key_dn   = 1'b1;
        wait_pulse(n0, 80);
        cycles(40);
        key_dn = 1'b0;
        cycles(4);
        key_dn = 1'b1;
        cycles(60);
        key_dn = 1'b0;
        cycles(4);
        key_dn = 1'b1;
        cycles(80);
        key_dn = 1'b0;
        cycles(24);
        check("hold_vld", vld_cnt - n0, 1);
        check("hold_bcd", {24'h0, bus.bcd_o}, 32'h91);

        // 5b. Two rows low in one column: ignored, scanning continues
        n0       = vld_cnt;
        key_rows = 4'b0101;
        key_col  = 2'd1;
        key_dn   = 1'b1;
        seen     = 4'h0;
        for (int i = 0; i < 24; i++) begin
            cycles(1);
            seen = seen | ~bus.columna_o;
        end
        key_dn = 1'b0;
        cycles(8);
        check("multi_novld", vld_cnt - n0, 0);
        check("multi_cols", {28'h0, seen}, 32'hF);

        // 6. Reset while held
        press_key("k4", 1, 0, 4'h4, 8'h14);
        press_key("k2", 0, 1, 4'h2, 8'h42);
        n0       = vld_cnt;
        key_rows = 4'b0100;
        key_col  = 2'd3;
        key_dn   = 1'b1;
        wait_pulse(n0, 80);
        cycles(8);
        check("held_bcd", {24'h0, bus.bcd_o}, 32'h42);
        rst_i = 1'b1;
        cycles(1);
        rst_i = 1'b0;
        check("rst2_bcd", {24'h0, bus.bcd_o}, 32'h00);
        check("rst2_col", {28'h0, bus.columna_o}, 32'hE);
        check("rst2_tecla", {28'h0, bus.tecla_o}, 32'h0);
        n0 = vld_cnt;
        wait_pulse(n0, 80);
        cycles(60);
        key_dn = 1'b0;
        cycles(24);
        check("rst2_reaccept", vld_cnt - n0, 1);
        check("rst2_tecla_c", {28'h0, last_tecla}, 32'hC);
        check("rst2_bcd_keep", {24'h0, bus.bcd_o}, 32'h00);

        check("vld_width", wide_vld, 0);
        check("enter_width", wide_enter, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
